// File: rtl/engine_stride_index_multi.sv
// Strided index generator: walks start..end (exclusive) by stride and deals the
// indices out in chunks of `granularity` to NUM_CHANNELS round-robin consumers.
module engine_stride_index_multi #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int CHAN_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic                    config_valid,
  output logic                    config_ready,
  input  logic                    config_increment,
  input  logic                    config_decrement,
  input  logic [ADDR_WIDTH-1:0]   config_index_start,
  input  logic [ADDR_WIDTH-1:0]   config_index_end,
  input  logic [ADDR_WIDTH-1:0]   config_stride,
  input  logic [ADDR_WIDTH-1:0]   config_granularity,
  input  logic                    pause_in,
  output logic [NUM_CHANNELS-1:0] out_valid,
  input  logic [NUM_CHANNELS-1:0] out_ready,
  output logic [ADDR_WIDTH-1:0]   out_index,
  output logic [CHAN_WIDTH-1:0]   out_chan,
  output logic                    out_chunk_last,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    config_error,
  output logic [ADDR_WIDTH-1:0]   emitted_count,
  output logic [2:0]              dbg_state
);

  // Handshakes: config transfers on an edge where config_valid && config_ready;
  // an index transfers where out_valid[out_chan] && out_ready[out_chan]; while
  // an offer waits, index/chan/flags hold and the offer is never withdrawn.

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_SETUP, S_BUSY, S_PAUSE_TRANS, S_PAUSE, S_DONE
  } state_t;

  state_t                state;
  logic                  offer;
  logic                  up_r;
  logic [ADDR_WIDTH-1:0] end_r;
  logic [ADDR_WIDTH-1:0] stride_r;
  logic [ADDR_WIDTH-1:0] gran_r;
  logic [ADDR_WIDTH-1:0] chunk_pos;

  assign dbg_state = state;

  function automatic logic [ADDR_WIDTH:0] step(input logic [ADDR_WIDTH-1:0] cur,
                                               input logic up,
                                               input logic [ADDR_WIDTH-1:0] s);
    step = up ? ({1'b0, cur} + {1'b0, s}) : ({1'b0, cur} - {1'b0, s});
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] v,
                                    input logic up,
                                    input logic [ADDR_WIDTH-1:0] e);
    in_range = up ? (v < e) : (v > e);
  endfunction

  // Look two indices ahead so the last/chunk_last flags can be registered
  // together with the index they describe. Bit ADDR_WIDTH is carry/borrow.
  logic [ADDR_WIDTH:0]   nxt1, nxt2;
  logic                  fin1, fin2, first_ok, hs, pos_wrap, bad_cfg;
  logic [ADDR_WIDTH-1:0] adv_pos;
  logic [CHAN_WIDTH-1:0] adv_chan;
  logic                  adv_chunk_last;

  always_comb begin
    nxt1           = step(out_index, up_r, stride_r);
    fin1           = nxt1[ADDR_WIDTH] || !in_range(nxt1[ADDR_WIDTH-1:0], up_r, end_r);
    nxt2           = step(nxt1[ADDR_WIDTH-1:0], up_r, stride_r);
    fin2           = nxt2[ADDR_WIDTH] || !in_range(nxt2[ADDR_WIDTH-1:0], up_r, end_r);
    first_ok       = in_range(out_index, up_r, end_r);
    hs             = offer && out_ready[out_chan];
    pos_wrap       = (chunk_pos == gran_r - ADDR_WIDTH'(1));
    adv_pos        = pos_wrap ? '0 : chunk_pos + ADDR_WIDTH'(1);
    adv_chan       = out_chan;
    if (pos_wrap) begin
      adv_chan = (out_chan == CHAN_WIDTH'(NUM_CHANNELS - 1)) ? '0 : out_chan + CHAN_WIDTH'(1);
    end
    adv_chunk_last = fin2 || (adv_pos == gran_r - ADDR_WIDTH'(1));
    bad_cfg        = (config_increment == config_decrement) || (config_stride == '0);
  end

  always_comb begin
    out_valid = '0;
    if (offer) out_valid[out_chan] = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state          <= S_RESET;
      offer          <= 1'b0;
      config_ready   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      config_error   <= 1'b0;
      emitted_count  <= '0;
      out_chan       <= '0;
      out_index      <= '0;
      out_chunk_last <= 1'b0;
      out_last       <= 1'b0;
      chunk_pos      <= '0;
      up_r           <= 1'b1;
      end_r          <= '0;
      stride_r       <= '0;
      gran_r         <= ADDR_WIDTH'(1);
    end else begin
      config_error <= 1'b0;
      case (state)
        S_RESET: begin
          state        <= S_IDLE;
          config_ready <= 1'b1;
        end
        S_IDLE, S_DONE: begin
          if (config_valid) begin
            done <= 1'b0;
            if (bad_cfg) begin
              config_error <= 1'b1;
              state        <= S_IDLE;
            end else begin
              up_r          <= config_increment;
              end_r         <= config_index_end;
              stride_r      <= config_stride;
              gran_r        <= (config_granularity == '0) ? ADDR_WIDTH'(1) : config_granularity;
              out_index     <= config_index_start;
              out_chan      <= '0;
              chunk_pos     <= '0;
              emitted_count <= '0;
              busy          <= 1'b1;
              config_ready  <= 1'b0;
              state         <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (first_ok) begin
            offer          <= 1'b1;
            out_last       <= fin1;
            out_chunk_last <= fin1 || pos_wrap;
            state          <= S_BUSY;
          end else begin
            done         <= 1'b1;
            busy         <= 1'b0;
            config_ready <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_BUSY, S_PAUSE_TRANS: begin
          if (hs) begin
            emitted_count <= emitted_count + ADDR_WIDTH'(1);
            if (out_last) begin
              offer        <= 1'b0;
              done         <= 1'b1;
              busy         <= 1'b0;
              config_ready <= 1'b1;
              state        <= S_DONE;
            end else begin
              out_index      <= nxt1[ADDR_WIDTH-1:0];
              out_chan       <= adv_chan;
              chunk_pos      <= adv_pos;
              out_last       <= fin2;
              out_chunk_last <= adv_chunk_last;
              if (pause_in || state == S_PAUSE_TRANS) begin
                offer <= 1'b0;
                state <= S_PAUSE;
              end else begin
                state <= S_BUSY;
              end
            end
          end else if (pause_in) begin
            state <= S_PAUSE_TRANS;
          end
        end
        S_PAUSE: begin
          if (!pause_in) begin
            offer <= 1'b1;
            state <= S_BUSY;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_engine_stride_index_multi.sv
// Randomised bench for engine_stride_index_multi: every transfer is checked
// against a sequence list computed directly from start/end/stride/granularity.
module tb_engine_stride_index_multi;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int CW = 2;
  localparam int IW = AW + CW + 2;
  localparam logic [N-1:0] ONE = 1;

  logic          ap_clk;
  logic          areset;
  logic          config_valid, config_ready, config_increment, config_decrement;
  logic [AW-1:0] config_index_start, config_index_end, config_stride, config_granularity;
  logic          pause_in;
  logic [N-1:0]  out_valid, out_ready;
  logic [AW-1:0] out_index;
  logic [CW-1:0] out_chan;
  logic          out_chunk_last, out_last, busy, done, config_error;
  logic [AW-1:0] emitted_count;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IW-1:0] exp_q[$];

  engine_stride_index_multi #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .CHAN_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .areset(areset),
    .config_valid(config_valid), .config_ready(config_ready),
    .config_increment(config_increment), .config_decrement(config_decrement),
    .config_index_start(config_index_start), .config_index_end(config_index_end),
    .config_stride(config_stride), .config_granularity(config_granularity),
    .pause_in(pause_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_chan(out_chan),
    .out_chunk_last(out_chunk_last), .out_last(out_last),
    .busy(busy), .done(done), .config_error(config_error),
    .emitted_count(emitted_count), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Reference: the index list, chunk dealing and flags from plain arithmetic.
  task automatic build_model(input logic inc, input logic [AW-1:0] s, input logic [AW-1:0] e,
                             input logic [AW-1:0] st, input logic [AW-1:0] g);
    logic [AW:0] cur, nxt;
    logic        ok, nok;
    int          k, ge;
    exp_q.delete();
    ge  = (g == 0) ? 1 : int'(g);
    cur = {1'b0, s};
    ok  = inc ? (s < e) : (s > e);
    k   = 0;
    while (ok && k < 400) begin
      nxt = inc ? (cur + {1'b0, st}) : (cur - {1'b0, st});
      nok = !nxt[AW] && (inc ? (nxt[AW-1:0] < e) : (nxt[AW-1:0] > e));
      exp_q.push_back({cur[AW-1:0], CW'((k / ge) % N), !nok || (k % ge == ge - 1), !nok});
      cur = nxt;
      ok  = nok;
      k++;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge ap_clk);
    #1;
    n_tests++;
    if ({out_valid, config_ready, busy, done, config_error, emitted_count, out_chan, out_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b rdy=%b busy=%b done=%b err=%b cnt=%0d chan=%0d idx=%0d, all required 0",
               out_valid, config_ready, busy, done, config_error, emitted_count, out_chan, out_index);
    end
    @(negedge ap_clk);
    areset = 1'b0;
    @(negedge ap_clk);
    #1;
    n_tests++;
    if (config_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: config_ready=%b required 1", config_ready);
    end
  endtask

  // rmode: 0 all ready, 1 random ready, 2 channel 1 stalls 3 cycles on index 2.
  // pmode: 0 none, 1 random pauses, 2 one pause burst once 4 indices moved.
  task automatic run_seq(input string name, input logic inc, input logic [AW-1:0] s,
                         input logic [AW-1:0] e, input logic [AW-1:0] st, input logic [AW-1:0] g,
                         input int rmode, input int pmode);
    int            cyc, hold, ppulse, xfers, exp_n;
    logic          fin, seen_valid, prev_pause, prev_pend, hsn;
    logic [IW-1:0] held, cur_item, exp_item;
    build_model(inc, s, e, st, g);
    exp_n = exp_q.size();
    @(negedge ap_clk);
    config_increment = inc;  config_decrement = !inc;
    config_index_start = s;  config_index_end = e;
    config_stride = st;      config_granularity = g;
    config_valid = 1'b1;     pause_in = 1'b0;  out_ready = '1;
    #1;
    n_tests++;
    if (config_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cfg_ready: config_ready=%b required 1", name, config_ready);
    end
    @(negedge ap_clk);
    config_valid = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b1 || out_valid !== '0 || emitted_count !== '0) begin
      n_fail++;
      $display("FAIL %s setup: busy=%b valid=%b cnt=%0d required busy=1 valid=0 cnt=0",
               name, busy, out_valid, emitted_count);
    end
    cyc = 0; hold = 0; ppulse = 0; xfers = 0;
    fin = 1'b0; seen_valid = 1'b0; prev_pause = 1'b0; prev_pend = 1'b0; held = '0;
    while (!fin && cyc < 4000) begin
      @(negedge ap_clk);
      case (rmode)
        1: out_ready = N'($urandom);
        2: begin
          out_ready = '1;
          if (out_valid != '0 && out_index == AW'(2) && hold < 3) begin
            out_ready[1] = 1'b0;
            hold++;
          end
        end
        default: out_ready = '1;
      endcase
      case (pmode)
        1: pause_in = seen_valid && ($urandom_range(0, 5) == 0);
        2: begin
          pause_in = (xfers >= 4) && (ppulse < 3);
          if (pause_in) ppulse++;
        end
        default: pause_in = 1'b0;
      endcase
      #1;
      if (cyc == 0) begin
        n_tests++;
        if (exp_n > 0 ? (out_valid === '0) : (done !== 1'b1)) begin
          n_fail++;
          $display("FAIL %s latency: valid=%b done=%b expected %0d transfers to start now",
                   name, out_valid, done, exp_n);
        end
      end
      n_tests++;
      if (emitted_count !== AW'(xfers)) begin
        n_fail++;
        $display("FAIL %s count: emitted_count=%0d required %0d", name, emitted_count, xfers);
      end
      n_tests++;
      if (out_valid !== '0 && out_valid !== (ONE << out_chan)) begin
        n_fail++;
        $display("FAIL %s onehot: out_valid=%b chan=%0d", name, out_valid, out_chan);
      end
      if (prev_pause && !prev_pend) begin
        n_tests++;
        if (out_valid !== '0) begin
          n_fail++;
          $display("FAIL %s pause_quiet: out_valid=%b required 0", name, out_valid);
        end
      end
      cur_item = {out_index, out_chan, out_chunk_last, out_last};
      if (prev_pend) begin
        n_tests++;
        if (out_valid === '0 || cur_item !== held) begin
          n_fail++;
          $display("FAIL %s hold: valid=%b item=%h required held item %h", name, out_valid, cur_item, held);
        end
      end
      hsn = out_valid[out_chan] && out_ready[out_chan];
      if (out_valid != '0) seen_valid = 1'b1;
      if (hsn) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra: index %0d chan %0d beyond expected sequence", name, out_index, out_chan);
        end else begin
          exp_item = exp_q.pop_front();
          if (cur_item !== exp_item) begin
            n_fail++;
            $display("FAIL %s xfer%0d: idx=%0d chan=%0d cl=%b last=%b required idx=%0d chan=%0d cl=%b last=%b",
                     name, xfers, out_index, out_chan, out_chunk_last, out_last,
                     exp_item[IW-1 -: AW], exp_item[CW+1:2], exp_item[1], exp_item[0]);
          end
        end
        xfers++;
      end
      prev_pend  = (out_valid != '0) && !hsn;
      held       = cur_item;
      prev_pause = pause_in;
      fin        = (done === 1'b1);
      cyc++;
    end
    pause_in  = 1'b0;
    out_ready = '1;
    n_tests++;
    if (!fin || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s complete: done_seen=%b left=%0d after %0d cycles, required done with 0 left",
               name, fin, exp_q.size(), cyc);
    end
    n_tests++;
    if (busy !== 1'b0 || out_valid !== '0 || config_ready !== 1'b1 || emitted_count !== AW'(exp_n)) begin
      n_fail++;
      $display("FAIL %s done_state: busy=%b valid=%b rdy=%b cnt=%0d required 0,0,1,%0d",
               name, busy, out_valid, config_ready, emitted_count, exp_n);
    end
  endtask

  task automatic test_config_error(input string name, input logic inc, input logic dec,
                                   input logic [AW-1:0] st);
    @(negedge ap_clk);
    config_increment = inc;  config_decrement = dec;
    config_index_start = 8'd0;  config_index_end = 8'd10;
    config_stride = st;  config_granularity = 8'd1;
    config_valid = 1'b1;
    @(negedge ap_clk);
    config_valid = 1'b0;
    #1;
    n_tests++;
    if (config_error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || config_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pulse: err=%b busy=%b done=%b rdy=%b required 1,0,0,1",
               name, config_error, busy, done, config_ready);
    end
    @(negedge ap_clk);
    #1;
    n_tests++;
    if (config_error !== 1'b0 || out_valid !== '0) begin
      n_fail++;
      $display("FAIL %s one_cycle: err=%b valid=%b required 0,0", name, config_error, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge ap_clk);
    config_increment = 1'b1;  config_decrement = 1'b0;
    config_index_start = 8'd0;  config_index_end = 8'd100;
    config_stride = 8'd1;  config_granularity = 8'd3;
    config_valid = 1'b1;  out_ready = '1;
    @(negedge ap_clk);
    config_valid = 1'b0;
    repeat (6) @(negedge ap_clk);
    areset = 1'b1;
    @(negedge ap_clk);
    #1;
    n_tests++;
    if ({out_valid, config_ready, busy, done, config_error, emitted_count, out_chan, out_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b rdy=%b busy=%b done=%b err=%b cnt=%0d chan=%0d idx=%0d, all required 0",
               out_valid, config_ready, busy, done, config_error, emitted_count, out_chan, out_index);
    end
    areset = 1'b0;
    @(negedge ap_clk);
    #1;
    n_tests++;
    if (config_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ready: rdy=%b busy=%b required 1,0", config_ready, busy);
    end
    run_seq("after_reset", 1'b1, 8'd4, 8'd30, 8'd3, 8'd2, 0, 0);
  endtask

  task automatic test_random();
    logic          inc;
    logic [AW-1:0] s, e, st, g;
    for (int i = 0; i < 12; i++) begin
      inc = 1'($urandom_range(0, 1));
      s   = AW'($urandom);
      e   = AW'($urandom);
      st  = AW'($urandom_range(1, 40));
      g   = AW'($urandom_range(0, 4));
      run_seq("random", inc, s, e, st, g, 1, 1);
    end
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_a", 1'b1, 8'd10, 8'd40, 8'd7, 8'd3, 0, 0);
    run_seq("b2b_b", 1'b0, 8'd200, 8'd150, 8'd9, 8'd2, 0, 0);
  endtask

  initial begin
    areset = 1'b1;  config_valid = 1'b0;  config_increment = 1'b1;  config_decrement = 1'b0;
    config_index_start = '0;  config_index_end = '0;  config_stride = '0;  config_granularity = '0;
    pause_in = 1'b0;  out_ready = '1;
    test_reset();
    run_seq("increment", 1'b1, 8'd0, 8'd10, 8'd1, 8'd2, 0, 0);
    run_seq("decrement", 1'b0, 8'd20, 8'd5, 8'd5, 8'd1, 0, 0);
    run_seq("empty_inc", 1'b1, 8'd5, 8'd5, 8'd1, 8'd1, 0, 0);
    run_seq("empty_dec", 1'b0, 8'd5, 8'd5, 8'd1, 8'd1, 0, 0);
    run_seq("backpressure", 1'b1, 8'd0, 8'd8, 8'd1, 8'd2, 2, 2);
    run_seq("overflow", 1'b1, 8'd250, 8'd255, 8'd4, 8'd1, 0, 0);
    run_seq("underflow", 1'b0, 8'd7, 8'd0, 8'd4, 8'd1, 0, 0);
    run_seq("gran_zero", 1'b1, 8'd3, 8'd20, 8'd2, 8'd0, 1, 0);
    test_config_error("err_both", 1'b1, 1'b1, 8'd1);
    test_config_error("err_none", 1'b0, 1'b0, 8'd1);
    test_config_error("err_stride", 1'b1, 1'b0, 8'd0);
    test_back_to_back();
    test_config_error("err_from_done", 1'b1, 1'b1, 8'd2);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/engine_stride_index_multi.md
ENGINE_STRIDE_INDEX_MULTI -- requirements
Module: engine_stride_index_multi

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of downstream compute-unit channels (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, width of every index/stride/granularity field.
REQ-003 SHALL have parameter CHAN_WIDTH, default $clog2(NUM_CHANNELS) (min 1), width of channel id.
REQ-004 SHALL have port ap_clk  input  1  sole clock; every flop rises on ap_clk.
REQ-005 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port config_valid  input  1  configuration offered.
REQ-007 SHALL have port config_ready  output  1  configuration accepted this cycle when high with config_valid.
REQ-008 SHALL have port config_increment, config_decrement  input  1 each  direction select.
REQ-009 SHALL have port config_index_start, config_index_end, config_stride, config_granularity  input  ADDR_WIDTH each  sequence parameters.
REQ-010 SHALL have port pause_in  input  1  request to suspend generation.
REQ-011 SHALL have port out_valid  output  NUM_CHANNELS  one-hot per-channel valid.
REQ-012 SHALL have port out_ready  input  NUM_CHANNELS  per-channel ready.
REQ-013 SHALL have port out_index  output  ADDR_WIDTH  shared index bus; out_chan  output  CHAN_WIDTH  channel of current index.
REQ-014 SHALL have port out_chunk_last, out_last  output  1 each  last index of chunk / of whole sequence.
REQ-015 SHALL have port busy, done, config_error  output  1 each; emitted_count  output  ADDR_WIDTH  indices transferred.

Function
REQ-016 SHALL implement states RESET, IDLE, SETUP, BUSY, PAUSE_TRANS, PAUSE, DONE.
REQ-017 SHALL assert config_ready only in IDLE or DONE; acceptance = config_valid && config_ready.
REQ-018 SHALL reject a config when increment==decrement, or stride==0: pulse config_error one cycle, remain/return to IDLE, done low.
REQ-019 SHALL treat granularity 0 as 1.
REQ-020 SHALL on acceptance latch parameters, clear emitted_count, set channel 0, go SETUP; SETUP goes BUSY next cycle; first out_valid SHALL assert in the cycle after SETUP (2 cycles after acceptance).
REQ-021 SHALL emit, increment mode, idx = start, start+stride, ... while idx < index_end; decrement mode while idx > index_end (index_end exclusive).
REQ-022 SHALL go directly SETUP->DONE with zero transfers when the first index already fails the REQ-021 test.
REQ-023 SHALL terminate after the current index if the next step carries out of / borrows below ADDR_WIDTH (no wrap-around emitted).
REQ-024 SHALL drive exactly one bit of out_valid (bit out_chan) high in BUSY when an index is offered; all zero otherwise.
REQ-025 SHALL hold out_index, out_chan, out_chunk_last, out_last stable while out_valid is high and out_ready[out_chan] is low.
REQ-026 SHALL count a transfer when out_valid[out_chan] && out_ready[out_chan]; out_ready of other channels SHALL be ignored.
REQ-027 SHALL send granularity consecutive indices to a channel, then advance out_chan by 1 mod NUM_CHANNELS; out_chunk_last SHALL mark each chunk's final index or the sequence's final index.
REQ-028 SHALL sustain one transfer per cycle when the addressed ready stays high.
REQ-029 SHALL, on pause_in high in BUSY, enter PAUSE_TRANS, keep an already-offered index valid until transferred, then enter PAUSE with out_valid zero; pause_in low in PAUSE returns to BUSY next cycle, resuming at the next index and same chunk position.
REQ-030 SHALL, after the out_last transfer, enter DONE: done=1, busy=0, out_valid=0; done SHALL hold until a new config is accepted.
REQ-031 SHALL assert busy in SETUP, BUSY, PAUSE_TRANS, PAUSE.
REQ-032 SHALL make emitted_count equal transfers since last acceptance, ADDR_WIDTH wide.

Reset
REQ-033 SHALL, while areset is high at a clock edge, enter RESET then IDLE, forcing out_valid=0, config_ready=0 in RESET, busy=0, done=0, config_error=0, emitted_count=0, out_chan=0, out_index=0, regardless of prior state, discarding any in-flight sequence.
REQ-034 SHALL raise config_ready the first cycle after areset falls.

Verification
REQ-035 Increment: start=0,end=10,stride=1,gran=2,NUM_CHANNELS=4, all ready -> indices 0..9 on chans 0,0,1,1,2,2,3,3,0,0; chunk_last on 1,3,5,7,9; out_last on 9; emitted_count=10; done.
REQ-036 Decrement: start=20,end=5,stride=5,gran=1 -> 20,15,10 on chans 0,1,2; out_last on 10; start=5,end=5 -> DONE, zero transfers.
REQ-037 Backpressure/pause: out_ready[1] low 3 cycles on index 2 and pause_in pulsed mid-chunk -> index 2 held stable, no extra/lost indices, order unchanged.
REQ-038 Overflow: ADDR_WIDTH=8,start=250,end=255,stride=4 -> 250,254 emitted, no wrapped index.
REQ-039 Error/reset: increment=decrement=1 -> config_error one-cycle pulse, IDLE; areset mid-sequence -> all outputs at reset values next cycle, new config accepted afterwards.
